// File: rtl/count_bank_pkg.sv
// Shared constants and types for the count bank scheduler.
// Build option: COUNT_BANK_SAT_EN selects saturating counts.
package count_bank_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 2;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;
  typedef logic [SEL_W-1:0]  sel_t;

  function automatic sel_t onehot2idx(ch_mask_t oh);
    sel_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | sel_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/count_bank_sched_rr_arb.sv
// Combinational round-robin pick: first eligible channel
// at or after the pointer, wrapping modulo NUM_CH.
module rr_arb
  import count_bank_pkg::*;
(
  input  ch_mask_t eligible,
  input  sel_t     ptr,
  output ch_mask_t grant,
  output logic     valid,
  output sel_t     idx
);

  sel_t c;

  // Walk offsets high to low so the nearest offset wins.
  always_comb begin
    grant = '0;
    c     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = ptr + sel_t'(k);
      if (eligible[c]) grant = ch_mask_t'(1) << c;
    end
  end

  assign valid = |grant;
  assign idx   = onehot2idx(grant);

endmodule

// File: rtl/count_bank_sched.sv
// NUM_CH count registers sharing one registered +1 stage.
// Build option: COUNT_BANK_SAT_EN saturates instead of wrapping.
module count_bank_sched
  import count_bank_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NUM_CH-1:0] iReq,
  input  logic [NUM_CH-1:0] iClr,
  input  logic [SEL_W-1:0]  iRdSel,
  output logic [CNT_W-1:0]  oRdData,
  output logic [NUM_CH-1:0] oAck,
  output logic [NUM_CH-1:0] oWrap,
  output logic              oBusy
);

  cnt_t     cnt [NUM_CH];
  ch_mask_t wrap;

  logic     s1_vld;
  sel_t     s1_ch;
  cnt_t     s1_sum;
  logic     s1_wrap;
  sel_t     ptr;

  ch_mask_t inflight;
  ch_mask_t eligible;
  ch_mask_t g_mask;
  logic     g_vld;
  sel_t     g_idx;
  cnt_t     g_cnt;
  logic     g_full;
  cnt_t     g_sum;

  // The in-flight channel is masked so its count is never read stale.
  assign inflight = s1_vld ? (ch_mask_t'(1) << s1_ch) : '0;
  assign eligible = iReq & ~inflight;

  rr_arb u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (g_mask),
    .valid    (g_vld),
    .idx      (g_idx)
  );

  assign g_cnt  = cnt[g_idx];
  assign g_full = &g_cnt;

`ifdef COUNT_BANK_SAT_EN
  assign g_sum = g_full ? g_cnt : g_cnt + cnt_t'(1);
`else
  assign g_sum = g_cnt + cnt_t'(1);
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_sum  <= '0;
      s1_wrap <= 1'b0;
      ptr     <= '0;
    end else begin
      // A clear on the granted channel cancels the increment.
      s1_vld <= g_vld & ~iClr[g_idx];
      if (g_vld) begin
        s1_ch   <= g_idx;
        s1_sum  <= g_sum;
        s1_wrap <= g_full;
        ptr     <= g_idx + sel_t'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (iRst) begin
        cnt[i]  <= '0;
        wrap[i] <= 1'b0;
      end else if (iClr[i]) begin
        cnt[i]  <= '0;
        wrap[i] <= 1'b0;
      end else if (s1_vld && s1_ch == sel_t'(i)) begin
        cnt[i] <= s1_sum;
        if (s1_wrap) wrap[i] <= 1'b1;
      end
    end
  end

  assign oRdData = cnt[iRdSel];
  assign oAck    = inflight;
  assign oWrap   = wrap;
  assign oBusy   = s1_vld;

endmodule

// File: tb/tb_count_bank_sched.sv
// Bench for count_bank_sched: directed scenarios plus random traffic
// against a transaction-level model of the counters.
module tb_count_bank_sched;
  import count_bank_pkg::*;

  localparam int MAXV = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] clr;
  logic [SEL_W-1:0]  sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] wrap;
  logic              busy;

  int total = 0;
  int bad   = 0;

  int m_cnt [NUM_CH];
  bit m_wrap [NUM_CH];
  bit p_vld;
  int p_ch;
  int p_val;
  bit p_wrap;
  int m_ptr;

  always #10 clk = ~clk;

  count_bank_sched dut (
    .iClk    (clk),
    .iRst    (rst),
    .iReq    (req),
    .iClr    (clr),
    .iRdSel  (sel),
    .oRdData (rd_data),
    .oAck    (ack),
    .oWrap   (wrap),
    .oBusy   (busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_ack();
    logic [NUM_CH-1:0] a;
    a = '0;
    if (p_vld) a[p_ch] = 1'b1;
    return a;
  endfunction

  function automatic logic [NUM_CH-1:0] m_wrap_mask();
    logic [NUM_CH-1:0] w;
    for (int i = 0; i < NUM_CH; i++) w[i] = m_wrap[i];
    return w;
  endfunction

  task automatic model_edge(bit r, logic [NUM_CH-1:0] rq,
                            logic [NUM_CH-1:0] cl);
    int g;
    int c;
    bit n_vld;
    int n_ch;
    int n_val;
    bit n_wrap;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i]  = 0;
        m_wrap[i] = 0;
      end
      p_vld = 0;
      m_ptr = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (m_ptr + k) % NUM_CH;
      if (g < 0 && rq[c] && !(p_vld && p_ch == c)) g = c;
    end
    n_vld = 0; n_ch = 0; n_val = 0; n_wrap = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NUM_CH;
      if (!cl[g]) begin
        n_vld  = 1;
        n_ch   = g;
        n_wrap = (m_cnt[g] == MAXV);
`ifdef COUNT_BANK_SAT_EN
        n_val = n_wrap ? MAXV : m_cnt[g] + 1;
`else
        n_val = (m_cnt[g] + 1) % (MAXV + 1);
`endif
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cl[i]) begin
        m_cnt[i]  = 0;
        m_wrap[i] = 0;
      end else if (p_vld && p_ch == i) begin
        m_cnt[i] = p_val;
        if (p_wrap) m_wrap[i] = 1;
      end
    end
    p_vld = n_vld; p_ch = n_ch; p_val = n_val; p_wrap = n_wrap;
  endtask

  task automatic cyc(bit r, logic [NUM_CH-1:0] rq,
                     logic [NUM_CH-1:0] cl, logic [SEL_W-1:0] s);
    @(negedge clk);
    rst = r; req = rq; clr = cl; sel = s;
    #1;
    check("ack", ack, m_ack());
    check("busy", busy, p_vld);
    check("wrap", wrap, m_wrap_mask());
    check("rd", rd_data, m_cnt[s]);
    @(posedge clk);
    model_edge(r, rq, cl);
  endtask

  task automatic peek_cnt(string tag, int ch, int exp);
    sel = SEL_W'(ch);
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    logic [NUM_CH-1:0] rc;
    rst = 1'b1; req = '0; clr = '0; sel = '0;
    p_vld = 0; p_ch = 0; p_val = 0; p_wrap = 0; m_ptr = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0;
    end

    // single requester: every other cycle
    cyc(1, '0, '0, '0);
    for (int i = 0; i < 8; i++) cyc(0, 4'b0001, '0, '0);
    peek_cnt("single_cnt0", 0, 4);

    // all requesting: one grant per cycle
    cyc(1, '0, '0, '0);
    for (int i = 0; i < 8; i++) cyc(0, 4'b1111, '0, '0);
    cyc(0, '0, '0, '0);
    for (int i = 0; i < NUM_CH; i++) peek_cnt("all_cnt", i, 2);

    // wrap / saturate on channel 2
    cyc(1, '0, '0, '0);
    for (int i = 0; i < 508; i++) cyc(0, 4'b0100, '0, 2'd2);
    peek_cnt("pre_fe", 2, 8'hFE);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0100, '0, 2'd2);
    cyc(0, '0, '0, 2'd2);
`ifdef COUNT_BANK_SAT_EN
    peek_cnt("sat_cnt2", 2, 8'hFF);
`else
    peek_cnt("wrap_cnt2", 2, 0);
`endif
    check("wrap_flag", wrap, 4'b0100);
    cyc(0, '0, 4'b0100, 2'd2);
    #1;
    check("wrap_clr", wrap, 4'b0000);
    peek_cnt("clr_cnt2", 2, 0);

    // clear in the grant cycle of channel 1
    cyc(1, '0, '0, '0);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0010, '0, 2'd1);
    peek_cnt("pre_clr_cnt1", 1, 5);
    cyc(0, 4'b0010, 4'b0010, 2'd1);
    #1;
    check("clr_grant_noack", ack, 4'b0000);
    peek_cnt("clr_grant_cnt1", 1, 0);
    cyc(0, 4'b1111, '0, '0);
    #1;
    check("ptr_after_clr", ack, 4'b0100);

    // clear in the writeback cycle of channel 3
    cyc(1, '0, '0, '0);
    cyc(0, 4'b1000, '0, 2'd3);
    #1;
    check("wb_clr_ack", ack, 4'b1000);
    cyc(0, '0, 4'b1000, 2'd3);
    peek_cnt("wb_clr_cnt3", 3, 0);

    // reset while busy
    cyc(1, '0, '0, '0);
    cyc(0, 4'b0110, '0, '0);
    #1;
    check("rst_busy_pre", busy, 1'b1);
    cyc(1, 4'b0110, '0, '0);
    #1;
    check("rst_noack", ack, 4'b0000);
    check("rst_nobusy", busy, 1'b0);
    check("rst_wrap", wrap, 4'b0000);
    for (int i = 0; i < NUM_CH; i++) peek_cnt("rst_cnt", i, 0);
    cyc(0, 4'b0110, '0, '0);
    #1;
    check("rst_next_grant", ack, 4'b0010);

    // random traffic
    cyc(1, '0, '0, '0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) rc[i] = ($urandom_range(0, 15) == 0);
      cyc(($urandom_range(0, 199) == 0), NUM_CH'($urandom), rc,
          SEL_W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
